ro_race_counter: RTL

Multi-channel ring-oscillator race counter for the RO-based PUF. On `start` it clears `CHANNELS` edge counters, counts synchronised rising edges from each RO input and stops when the first counter reaches `THRESHOLD`. It then reports the winning channel, a tie flag and the winner's margin over the runner-up. It replaces the single-channel, level-counting threshold counter and feeds the PUF response/compare logic.

---
 rtl/ro_puf_pkg.sv | 19 +
 rtl/ro_edge_sync.sv | 28 ++
 rtl/ro_race_counter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types for the RO-PUF blocks: race FSM state encoding and the
// channel-index width helper.
package ro_puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } race_state_t;

    // Width of a channel index; one channel still needs a 1-bit field.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned WINNER_W_MIN = sel_width(2);

endpackage

// File: rtl/ro_edge_sync.sv
// Brings one asynchronous ring-oscillator line into the clk domain and emits
// a one-cycle pulse per synchronised rising edge.
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic ro,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= ro;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/ro_race_counter.sv
// Multi-channel RO race counter: counts synchronised edges per channel until
// one reaches THRESHOLD, then reports winner, tie and margin.
// Optional RUN-length limit enabled by defining RO_RACE_TIMEOUT_EN.
module ro_race_counter
    import ro_puf_pkg::*;
#(
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned WIDTH          = 16,
    parameter int unsigned THRESHOLD      = (32'd1 << WIDTH) - 32'd1,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1 << 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CHANNELS-1:0]            ro_in,
    output logic                           busy,
    output logic                           done,
    output logic [sel_width(CHANNELS)-1:0] winner,
    output logic                           tie,
    output logic [WIDTH-1:0]               margin,
    output logic                           timeout
);

    localparam int unsigned WINNER_W = sel_width(CHANNELS);
    localparam logic [WIDTH-1:0] THR = WIDTH'(THRESHOLD);

    if (CHANNELS < 2 || THRESHOLD < 1 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
        $error("ro_race_counter: invalid CHANNELS/THRESHOLD/TIMEOUT_CYCLES");
    end

    race_state_t         state;
    logic [CHANNELS-1:0] edges;
    logic [WIDTH-1:0]    cnt      [CHANNELS];
    logic [WIDTH-1:0]    next_cnt [CHANNELS];
    logic                any_hit;
    logic                multi_hit;
    logic [WINNER_W-1:0] win_idx;
    logic [WIDTH-1:0]    runner;
    logic [WIDTH-1:0]    margin_next;
    logic                to_hit;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_sync
        ro_edge_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .ro    (ro_in[g]),
            .pulse (edges[g])
        );
    end

    // Reduction works on the post-update counts so results land on the hit edge.
    always_comb begin
        any_hit   = 1'b0;
        multi_hit = 1'b0;
        win_idx   = '0;
        runner    = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            next_cnt[i] = cnt[i];
            if (state == RUN && edges[i] && cnt[i] != THR)
                next_cnt[i] = cnt[i] + WIDTH'(1);
        end
        for (int unsigned i = CHANNELS; i > 0; i--) begin
            if (next_cnt[i-1] == THR) begin
                if (any_hit)
                    multi_hit = 1'b1;
                any_hit = 1'b1;
                win_idx = WINNER_W'(i-1);
            end
        end
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (WINNER_W'(i) != win_idx && next_cnt[i] > runner)
                runner = next_cnt[i];
        end
        margin_next = multi_hit ? '0 : THR - runner;
    end

`ifdef RO_RACE_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] run_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            run_cycles <= '0;
        else if (state == CLEAR)
            run_cycles <= '0;
        else if (state == RUN)
            run_cycles <= run_cycles + TO_W'(1);
    end

    // Fires on the edge that completes the TIMEOUT_CYCLES-th RUN cycle.
    assign to_hit = (state == RUN) && (run_cycles == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
        end else if (state == CLEAR) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt[i] <= '0;
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < CHANNELS; i++)
                cnt[i] <= next_cnt[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            winner  <= '0;
            tie     <= 1'b0;
            margin  <= '0;
            timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= RUN;
                end
                RUN: begin
                    if (any_hit) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        winner  <= win_idx;
                        tie     <= multi_hit;
                        margin  <= margin_next;
                        timeout <= 1'b0;
                    end else if (to_hit) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        winner  <= '0;
                        tie     <= 1'b0;
                        margin  <= '0;
                        timeout <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state   <= CLEAR;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        winner  <= '0;
                        tie     <= 1'b0;
                        margin  <= '0;
                        timeout <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
